// File: rtl/fft_pkg.sv
// Shared FFT datapath types. `FFT_DATA_WIDTH sets the per-part sample width and defaults to 16.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

package fft_pkg;

   localparam int FFT_W = `FFT_DATA_WIDTH;

   typedef struct packed {
      logic signed [FFT_W-1:0] data_r;
      logic signed [FFT_W-1:0] data_i;
   } FFT_DATA_SAMPLE;

   // One guard bit per part, so a sum or difference of two samples never wraps.
   typedef struct packed {
      logic signed [FFT_W:0] r;
      logic signed [FFT_W:0] i;
   } FFT_WIDE_SAMPLE;

   function automatic logic signed [FFT_W:0] wide_sub(input logic signed [FFT_W-1:0] a,
                                                      input logic signed [FFT_W-1:0] b);
      return {a[FFT_W-1], a} - {b[FFT_W-1], b};
   endfunction

endpackage

// File: rtl/fft_sat_wide2n.sv
// Narrows a W+1-bit signed value to W bits. The default is to clip to the W-bit range and flag the clip.
// When FFT_CSUB_HALF_EN is defined, it outputs (d+1)>>>1 instead, with the flag tied low.
module fft_sat_wide2n #(
   parameter int W = 16
) (
   input  logic signed [W:0]   d,
   output logic signed [W-1:0] q,
   output logic                clip
);

   localparam logic signed [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

`ifdef FFT_CSUB_HALF_EN
   logic signed [W+1:0] h;

   // Only +2^W halves to +2^(W-1), which is one past the maximum, so it is clamped silently.
   always_comb begin
      h    = $signed({d[W], d} + (W+2)'(1)) >>> 1;
      q    = h[W-1:0];
      clip = 1'b0;
      if (h[W+1:W-1] != 3'b000 && h[W+1:W-1] != 3'b111)
         q = h[W+1] ? Q_MIN : Q_MAX;
   end
`else
   always_comb begin
      q    = d[W-1:0];
      clip = 1'b0;
      if (d[W] != d[W-1]) begin
         q    = d[W] ? Q_MIN : Q_MAX;
         clip = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/fft_csub_hs.sv
// Two-stage pipelined complex subtractor (out = opa - opb) with a valid/ready handshake.
// The result is saturated and every saturation is counted. FFT_CSUB_HALF_EN switches the output to a halved difference.
module fft_csub_hs
   import fft_pkg::*;
#(
   parameter int SAT_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  FFT_DATA_SAMPLE       opa,
   input  FFT_DATA_SAMPLE       opb,
   output logic                 out_valid,
   input  logic                 out_ready,
   output FFT_DATA_SAMPLE       out,
   output logic                 out_sat,
   input  logic                 sat_clr,
   output logic [SAT_CNT_W-1:0] sat_cnt
);

   localparam logic [SAT_CNT_W-1:0] CNT_MAX = '1;

   logic                    s1_valid, s2_valid;
   logic                    s1_adv, s2_adv;
   FFT_WIDE_SAMPLE          s1_d;
   logic signed [FFT_W-1:0] nar_r, nar_i;
   logic                    clip_r, clip_i;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_d     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_d.r <= wide_sub(opa.data_r, opb.data_r);
            s1_d.i <= wide_sub(opa.data_i, opb.data_i);
         end
      end
   end

   fft_sat_wide2n #(.W(FFT_W)) u_sat_r (.d(s1_d.r), .q(nar_r), .clip(clip_r));
   fft_sat_wide2n #(.W(FFT_W)) u_sat_i (.d(s1_d.i), .q(nar_i), .clip(clip_i));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out      <= '0;
         out_sat  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out.data_r <= nar_r;
            out.data_i <= nar_i;
            out_sat    <= clip_r | clip_i;
         end
      end
   end

   // A clear in the same cycle as a counted event wins, and that event is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_cnt <= '0;
      else if (sat_clr)
         sat_cnt <= '0;
      else if (s2_valid && out_ready && out_sat && sat_cnt != CNT_MAX)
         sat_cnt <= sat_cnt + SAT_CNT_W'(1);
   end

endmodule

// File: tb/tb_fft_csub_hs.sv
// Directed vectors and a scoreboard for fft_csub_hs. Two instances share stimulus: one with a 16-bit counter, one with a 2-bit counter.
module tb_fft_csub_hs;
   import fft_pkg::*;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0, out_ready = 1'b1, sat_clr = 1'b0;
   FFT_DATA_SAMPLE opa = '0, opb = '0;
   logic           in_ready, out_valid, out_sat;
   FFT_DATA_SAMPLE out;
   logic [15:0]    sat_cnt;
   logic           in_ready2, out_valid2, out_sat2;
   FFT_DATA_SAMPLE out2;
   logic [1:0]     sat_cnt2;

   always #5 clk = ~clk;

   fft_csub_hs #(.SAT_CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opa(opa), .opb(opb), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_sat(out_sat), .sat_clr(sat_clr), .sat_cnt(sat_cnt));

   fft_csub_hs #(.SAT_CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .opa(opa), .opb(opb), .out_valid(out_valid2), .out_ready(out_ready),
      .out(out2), .out_sat(out_sat2), .sat_clr(sat_clr), .sat_cnt(sat_cnt2));

   typedef struct {int r; int i; bit sat; int cyc;} item_t;
   typedef struct {int ar; int ai; int br; int bi; int er; int ei; bit es;} vec_t;

   item_t q[$];
   vec_t  tbl[6];
   int    n_chk = 0, n_err = 0;
   int    cyc = 0, n_out = 0;
   int    m_cnt16 = 0, m_cnt2 = 0;
   int    last_r, last_i;
   bit    last_sat;
   bit    prev_stall = 0;
   int    prev_r, prev_i;
   bit    prev_sat;

`ifdef FFT_CSUB_HALF_EN
   localparam int EXP5_16 = 0, EXP5_2 = 0, EXP_AFTER = 0;
`else
   localparam int EXP5_16 = 5, EXP5_2 = 3, EXP_AFTER = 1;
`endif

   function automatic void chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic int mpart(input int d);
      int h;
`ifdef FFT_CSUB_HALF_EN
      h = (d + 1) >>> 1;
`else
      h = d;
`endif
      if (h > 32767) return 32767;
      if (h < -32768) return -32768;
      return h;
   endfunction

   function automatic bit msat(input int dr, input int di);
`ifdef FFT_CSUB_HALF_EN
      return 1'b0;
`else
      return (mpart(dr) != dr) || (mpart(di) != di);
`endif
   endfunction

   function automatic int rnd16();
      logic signed [15:0] v;
      v = 16'($urandom);
      return int'(v);
   endfunction

   task automatic step(input bit vin, input int ar, input int ai, input int br, input int bi,
                       input bit ordy, input bit clr, input bit clr_on_out);
      bit    exp_v, exp_rdy, dq, acc;
      item_t it;
      @(negedge clk);
      in_valid    = vin;
      out_ready   = ordy;
      sat_clr     = clr;
      opa.data_r  = ar[15:0];
      opa.data_i  = ai[15:0];
      opb.data_r  = br[15:0];
      opb.data_i  = bi[15:0];
      #1;
      if (clr_on_out && out_valid && out_ready) sat_clr = 1'b1;
      exp_rdy = !(q.size() == 2 && !ordy);
      exp_v   = (q.size() > 0) && (cyc - q[0].cyc >= 2);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("in_ready2", int'(in_ready2), int'(exp_rdy));
      chk("out_valid", int'(out_valid), int'(exp_v));
      chk("out_valid2", int'(out_valid2), int'(exp_v));
      chk("sat_cnt", int'(sat_cnt), m_cnt16);
      chk("sat_cnt2", int'(sat_cnt2), m_cnt2);
      if (exp_v) begin
         chk("out_r", int'(out.data_r), q[0].r);
         chk("out_i", int'(out.data_i), q[0].i);
         chk("out_sat", int'(out_sat), int'(q[0].sat));
         chk("out2_r", int'(out2.data_r), q[0].r);
         chk("out2_sat", int'(out_sat2), int'(q[0].sat));
      end
      if (prev_stall) begin
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_r", int'(out.data_r), prev_r);
         chk("stall_i", int'(out.data_i), prev_i);
         chk("stall_sat", int'(out_sat), int'(prev_sat));
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = int'(out.data_r);
      prev_i     = int'(out.data_i);
      prev_sat   = out_sat;
      dq  = exp_v && ordy;
      acc = vin && exp_rdy;
      if (sat_clr) begin
         m_cnt16 = 0;
         m_cnt2  = 0;
      end else if (dq && q[0].sat) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      if (dq) begin
         last_r   = q[0].r;
         last_i   = q[0].i;
         last_sat = q[0].sat;
         last_r   = int'(out.data_r);
         last_i   = int'(out.data_i);
         last_sat = out_sat;
         n_out++;
         void'(q.pop_front());
      end
      if (acc) begin
         it.r   = mpart(ar - br);
         it.i   = mpart(ai - bi);
         it.sat = msat(ar - br, ai - bi);
         it.cyc = cyc;
         q.push_back(it);
      end
      cyc++;
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, rnd16(), rnd16(), rnd16(), rnd16(), ordy, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && q.size() > 0; k++) idle(1'b1);
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sat_clr   = 1'b0;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_r", int'(out.data_r), 0);
      chk("rst_out_sat", int'(out_sat), 0);
      chk("rst_sat_cnt", int'(sat_cnt), 0);
      chk("rst_sat_cnt2", int'(sat_cnt2), 0);
      q.delete();
      m_cnt16    = 0;
      m_cnt2     = 0;
      prev_stall = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int base;
`ifdef FFT_CSUB_HALF_EN
      tbl[0] = '{100, -5, 40, 7, 30, -6, 1'b0};
      tbl[1] = '{-32768, 0, 32767, 0, -32767, 0, 1'b0};
      tbl[2] = '{32767, 0, -32768, 1, 32767, 0, 1'b0};
      tbl[3] = '{-32768, -32768, -32768, -32768, 0, 0, 1'b0};
      tbl[4] = '{-32768, 32767, 32767, -32768, -32767, 32767, 1'b0};
      tbl[5] = '{0, 32767, 0, -1, 0, 16384, 1'b0};
`else
      tbl[0] = '{100, -5, 40, 7, 60, -12, 1'b0};
      tbl[1] = '{-32768, 0, 32767, 0, -32768, 0, 1'b1};
      tbl[2] = '{32767, 0, -32768, 1, 32767, -1, 1'b1};
      tbl[3] = '{-32768, -32768, -32768, -32768, 0, 0, 1'b0};
      tbl[4] = '{5, -3, 2, 4, 3, -7, 1'b0};
      tbl[5] = '{0, 32767, 0, -1, 0, 32767, 1'b1};
`endif
      do_reset();
      idle(1'b1);

      foreach (tbl[k]) begin
         base = n_out;
         step(1'b1, tbl[k].ar, tbl[k].ai, tbl[k].br, tbl[k].bi, 1'b1, 1'b0, 1'b0);
         for (int w = 0; w < 6 && n_out == base; w++) idle(1'b1);
         chk("tbl_count", n_out, base + 1);
         chk("tbl_r", last_r, tbl[k].er);
         chk("tbl_i", last_i, tbl[k].ei);
         chk("tbl_sat", int'(last_sat), int'(tbl[k].es));
      end

      base = n_out;
      for (int k = 0; k < 100; k++) step(1'b1, rnd16(), rnd16(), rnd16(), rnd16(), 1'b1, 1'b0, 1'b0);
      drain();
      chk("stream_count", n_out - base, 100);

      for (int k = 0; k < 5; k++) step(1'b1, rnd16(), rnd16(), rnd16(), rnd16(), 1'b1, 1'b0, 1'b0);
      do_reset();
      repeat (3) idle(1'b1);
      step(1'b1, 100, -5, 40, 7, 1'b1, 1'b0, 1'b0);
      drain();

      base = n_out;
      for (int k = 0; k < 200; k++)
         step($urandom_range(0, 9) < 7, rnd16(), rnd16(), rnd16(), rnd16(),
              1'($urandom_range(0, 1)), 1'b0, 1'b0);
      base = n_out - base + q.size();
      drain();

      step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b1, -32768, 0, 32767, 0, 1'b1, 1'b0, 1'b0);
      drain();
      @(posedge clk); #1;
      chk("cnt16_after5", int'(sat_cnt), EXP5_16);
      chk("cnt2_after5", int'(sat_cnt2), EXP5_2);
      step(1'b1, 32767, 0, -32768, 0, 1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("clr_wins16", int'(sat_cnt), 0);
      chk("clr_wins2", int'(sat_cnt2), 0);
      step(1'b1, 32767, 0, -32768, 0, 1'b1, 1'b0, 1'b0);
      drain();
      @(posedge clk); #1;
      chk("cnt_after_clr", int'(sat_cnt), EXP_AFTER);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
